// File: rtl/matrix_histogram_engine.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_histogram_engine
//  Description : ROWS x COLS 2-D histogram of (x,y) sample pairs accumulated
//                over a programmable dwell, frozen for registered readout.
//  Revision    : 1.0 - initial release
// ============================================================================
module matrix_histogram_engine #(
    parameter int IDX_W       = 6,
    parameter int RANGE_X_MIN = 0,
    parameter int RANGE_Y_MIN = 0,
    parameter int ROWS        = 3,
    parameter int COLS        = 3,
    parameter int CNT_W       = 8,
    parameter int DWELL_W     = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [DWELL_W-1:0]        dwell_len,
    input  logic                      sample_valid,
    input  logic [IDX_W-1:0]          x_index,
    input  logic [IDX_W-1:0]          y_index,
    input  logic                      rd_en,
    input  logic [$clog2(ROWS)-1:0]   rd_row,
    input  logic [$clog2(COLS)-1:0]   rd_col,
    output logic [CNT_W-1:0]          rd_data,
    output logic                      rd_valid,
    output logic                      busy,
    output logic                      done,
    output logic                      sat_flag,
    output logic [DWELL_W-1:0]        hit_count
);

    localparam int               C_NBINS   = ROWS * COLS;
    localparam int               C_BIN_W   = (C_NBINS > 1) ? $clog2(C_NBINS) : 1;
    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_ACCUM = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic [CNT_W-1:0]     r_bins [C_NBINS];
    logic [C_BIN_W-1:0]   r_clr_idx;
    logic [DWELL_W-1:0]   r_dwell;
    logic [DWELL_W-1:0]   r_samp_cnt;
    logic [DWELL_W-1:0]   r_hit_cnt;
    logic                 r_sat;
    logic [CNT_W-1:0]     r_rd_data;
    logic                 r_rd_valid;

    logic                 w_accept;
    logic                 w_sample;
    logic                 w_x_in;
    logic                 w_y_in;
    logic                 w_hit;
    logic [C_BIN_W-1:0]   w_wr_idx;
    logic [CNT_W-1:0]     w_cur;
    logic [DWELL_W-1:0]   w_samp_next;
    logic                 w_rd_in;
    logic [C_BIN_W-1:0]   w_rd_idx;
    logic                 w_clr_last;

    // Sample qualification and bin addressing
    assign w_x_in   = (32'(x_index) >= 32'(RANGE_X_MIN)) &&
                      (32'(x_index) <  32'(RANGE_X_MIN + ROWS));
    assign w_y_in   = (32'(y_index) >= 32'(RANGE_Y_MIN)) &&
                      (32'(y_index) <  32'(RANGE_Y_MIN + COLS));
    assign w_wr_idx = C_BIN_W'((32'(x_index) - 32'(RANGE_X_MIN)) * 32'(COLS) +
                               (32'(y_index) - 32'(RANGE_Y_MIN)));
    assign w_cur    = r_bins[w_wr_idx];

    assign w_accept    = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_sample    = (r_state == S_ACCUM) && sample_valid;
    assign w_hit       = w_sample && w_x_in && w_y_in;
    assign w_samp_next = r_samp_cnt + 1'b1;
    assign w_clr_last  = (r_clr_idx == C_BIN_W'(C_NBINS - 1));

    // Out-of-range read addresses return zero rather than aliasing a bin
    assign w_rd_in  = (32'(rd_row) < 32'(ROWS)) && (32'(rd_col) < 32'(COLS));
    assign w_rd_idx = C_BIN_W'(32'(rd_row) * 32'(COLS) + 32'(rd_col));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE:  if (start) w_state_next = S_CLEAR;
            S_CLEAR: if (w_clr_last) w_state_next = (r_dwell == '0) ? S_DONE : S_ACCUM;
            S_ACCUM: if (sample_valid && (w_samp_next == r_dwell)) w_state_next = S_DONE;
            S_DONE:  if (start) w_state_next = S_CLEAR;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < C_NBINS; i++) begin
                r_bins[i] <= '0;
            end
            r_clr_idx  <= '0;
            r_dwell    <= '0;
            r_samp_cnt <= '0;
            r_hit_cnt  <= '0;
            r_sat      <= 1'b0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            // Read samples the array before this edge's update: pre-increment value
            r_rd_valid <= rd_en;
            if (rd_en) begin
                r_rd_data <= w_rd_in ? r_bins[w_rd_idx] : '0;
            end

            if (w_accept) begin
                r_dwell    <= dwell_len;
                r_sat      <= 1'b0;
                r_hit_cnt  <= '0;
                r_samp_cnt <= '0;
                r_clr_idx  <= '0;
            end

            if (r_state == S_CLEAR) begin
                r_bins[r_clr_idx] <= '0;
                r_clr_idx         <= r_clr_idx + 1'b1;
            end

            if (w_sample) begin
                r_samp_cnt <= w_samp_next;
            end

            if (w_hit) begin
                r_hit_cnt <= r_hit_cnt + 1'b1;
                if (w_cur == C_CNT_MAX) begin
                    r_sat <= 1'b1;
                end else begin
                    r_bins[w_wr_idx] <= w_cur + 1'b1;
                end
            end
        end
    end

    assign rd_data   = r_rd_data;
    assign rd_valid  = r_rd_valid;
    assign busy      = (r_state == S_CLEAR) || (r_state == S_ACCUM);
    assign done      = (r_state == S_DONE);
    assign sat_flag  = r_sat;
    assign hit_count = r_hit_cnt;

endmodule
`default_nettype wire

// File: tb/tb_matrix_histogram_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_matrix_histogram_engine
//  Description : Directed self-checking bench for matrix_histogram_engine.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_matrix_histogram_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] dwell_len;
    logic        sample_valid;
    logic [5:0]  x_index;
    logic [5:0]  y_index;
    logic        rd_en;
    logic [1:0]  rd_row;
    logic [1:0]  rd_col;
    logic [3:0]  rd_data;
    logic        rd_valid;
    logic        busy;
    logic        done;
    logic        sat_flag;
    logic [15:0] hit_count;

    int total = 0;
    int bad   = 0;

    matrix_histogram_engine #(.CNT_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .dwell_len(dwell_len),
        .sample_valid(sample_valid), .x_index(x_index), .y_index(y_index),
        .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col),
        .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done),
        .sat_flag(sat_flag), .hit_count(hit_count)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input int r, input int c, output logic [3:0] d, output logic v);
        rd_en  = 1'b1;
        rd_row = 2'(r);
        rd_col = 2'(c);
        tick();
        d     = rd_data;
        v     = rd_valid;
        rd_en = 1'b0;
    endtask

    task automatic kick(input int dl);
        dwell_len = 16'(dl);
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic test_reset;
        logic [3:0] d;
        logic       v;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (sat_flag !== 1'b0) begin bad++; $display("FAIL reset_sat got=%b exp=0", sat_flag); end
        total++; if (hit_count !== 16'd0) begin bad++; $display("FAIL reset_hit got=%0d exp=0", hit_count); end
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rdv got=%b exp=0", rd_valid); end
        for (int i = 0; i < 9; i++) begin
            do_read(i / 3, i % 3, d, v);
            total++; if (d !== 4'd0 || v !== 1'b1) begin bad++; $display("FAIL reset_bin%0d got=%0d/%b exp=0/1", i, d, v); end
        end
        tick();
        total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL idle_rdv got=%b exp=0", rd_valid); end
        do_read(3, 0, d, v);
        total++; if (d !== 4'd0 || v !== 1'b1) begin bad++; $display("FAIL oob_read got=%0d/%b exp=0/1", d, v); end
    endtask

    task automatic test_basic;
        int         xs [5] = '{0, 0, 2, 7, 1};
        int         ys [5] = '{0, 0, 1, 7, 2};
        int         exp_bins [9] = '{2, 0, 0, 0, 0, 1, 0, 1, 0};
        logic [3:0] d;
        logic       v;
        kick(5);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy_clear got=%b exp=1", busy); end
        // Valid samples during the sweep must be dropped
        sample_valid = 1'b1; x_index = 6'd0; y_index = 6'd0;
        repeat (9) tick();
        total++; if (busy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL basic_after_clear got=%b%b exp=10", busy, done); end
        for (int i = 0; i < 5; i++) begin
            x_index = 6'(xs[i]); y_index = 6'(ys[i]);
            tick();
            if (i == 3) begin
                total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_early_done got=%b exp=0", done); end
            end
        end
        sample_valid = 1'b0;
        total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL basic_done got=%b%b exp=10", busy, done); end
        total++; if (hit_count !== 16'd4) begin bad++; $display("FAIL basic_hit got=%0d exp=4", hit_count); end
        total++; if (sat_flag !== 1'b0) begin bad++; $display("FAIL basic_sat got=%b exp=0", sat_flag); end
        for (int i = 0; i < 9; i++) begin
            do_read(i / 3, i % 3, d, v);
            total++; if (d !== 4'(exp_bins[i]) || v !== 1'b1) begin bad++; $display("FAIL basic_bin%0d got=%0d exp=%0d", i, d, exp_bins[i]); end
        end
    endtask

    task automatic test_saturation;
        logic [3:0] d;
        logic       v;
        kick(20);
        repeat (9) tick();
        sample_valid = 1'b1; x_index = 6'd1; y_index = 6'd1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 15) begin
                total++; if (sat_flag !== 1'b0) begin bad++; $display("FAIL sat_early got=%b exp=0", sat_flag); end
            end
            if (i == 16) begin
                total++; if (sat_flag !== 1'b1) begin bad++; $display("FAIL sat_set got=%b exp=1", sat_flag); end
            end
        end
        sample_valid = 1'b0;
        total++; if (done !== 1'b1) begin bad++; $display("FAIL sat_done got=%b exp=1", done); end
        total++; if (hit_count !== 16'd20) begin bad++; $display("FAIL sat_hit got=%0d exp=20", hit_count); end
        total++; if (sat_flag !== 1'b1) begin bad++; $display("FAIL sat_sticky got=%b exp=1", sat_flag); end
        do_read(1, 1, d, v);
        total++; if (d !== 4'd15) begin bad++; $display("FAIL sat_bin got=%0d exp=15", d); end
    endtask

    task automatic test_zero_dwell;
        logic [3:0] d;
        logic       v;
        kick(0);
        total++; if (sat_flag !== 1'b0 || hit_count !== 16'd0) begin bad++; $display("FAIL zd_cleared got=%b/%0d exp=0/0", sat_flag, hit_count); end
        repeat (8) tick();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL zd_busy8 got=%b exp=1", busy); end
        tick();
        total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL zd_done got=%b%b exp=10", busy, done); end
        for (int i = 0; i < 9; i++) begin
            do_read(i / 3, i % 3, d, v);
            total++; if (d !== 4'd0) begin bad++; $display("FAIL zd_bin%0d got=%0d exp=0", i, d); end
        end
    endtask

    task automatic test_accum_ctrl;
        logic [3:0] d;
        logic       v;
        kick(4);
        repeat (9) tick();
        sample_valid = 1'b1; x_index = 6'd0; y_index = 6'd0;
        tick();
        sample_valid = 1'b0;
        tick();
        start = 1'b1; dwell_len = 16'd0;
        tick();
        start = 1'b0;
        tick();
        total++; if (busy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL ctrl_idle got=%b%b exp=10", busy, done); end
        sample_valid = 1'b1; x_index = 6'd0; y_index = 6'd0;
        rd_en = 1'b1; rd_row = 2'd0; rd_col = 2'd0;
        tick();
        total++; if (rd_data !== 4'd1 || rd_valid !== 1'b1) begin bad++; $display("FAIL ctrl_rd_old got=%0d/%b exp=1/1", rd_data, rd_valid); end
        x_index = 6'd2; y_index = 6'd2;
        tick();
        total++; if (rd_data !== 4'd2) begin bad++; $display("FAIL ctrl_rd_new got=%0d exp=2", rd_data); end
        rd_en = 1'b0;
        x_index = 6'd5; y_index = 6'd5;
        tick();
        sample_valid = 1'b0;
        total++; if (done !== 1'b1) begin bad++; $display("FAIL ctrl_done got=%b exp=1", done); end
        total++; if (hit_count !== 16'd3) begin bad++; $display("FAIL ctrl_hit got=%0d exp=3", hit_count); end
        do_read(2, 2, d, v);
        total++; if (d !== 4'd1) begin bad++; $display("FAIL ctrl_bin22 got=%0d exp=1", d); end
    endtask

    task automatic test_reset_mid;
        logic [3:0] d;
        logic       v;
        kick(10);
        repeat (9) tick();
        sample_valid = 1'b1; x_index = 6'd2; y_index = 6'd0;
        repeat (3) tick();
        sample_valid = 1'b0;
        do_read(2, 0, d, v);
        total++; if (d !== 4'd3 || hit_count !== 16'd3) begin bad++; $display("FAIL mid_pre got=%0d/%0d exp=3/3", d, hit_count); end
        rst = 1'b1;
        tick();
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL mid_state got=%b%b exp=00", busy, done); end
        total++; if (hit_count !== 16'd0 || sat_flag !== 1'b0) begin bad++; $display("FAIL mid_flags got=%0d/%b exp=0/0", hit_count, sat_flag); end
        total++; if (rd_data !== 4'd0 || rd_valid !== 1'b0) begin bad++; $display("FAIL mid_rd got=%0d/%b exp=0/0", rd_data, rd_valid); end
        rst = 1'b0;
        for (int i = 0; i < 9; i++) begin
            do_read(i / 3, i % 3, d, v);
            total++; if (d !== 4'd0 || v !== 1'b1) begin bad++; $display("FAIL mid_bin%0d got=%0d/%b exp=0/1", i, d, v); end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; dwell_len = '0; sample_valid = 1'b0;
        x_index = '0; y_index = '0; rd_en = 1'b0; rd_row = '0; rd_col = '0;
        test_reset();
        test_basic();
        test_saturation();
        test_zero_dwell();
        test_accum_ctrl();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/matrix_histogram_engine.md
Name: matrix_histogram_engine

Overview:
- Parametrised successor to the 3x3 constellation bin counter in the SDR receive path.
- Accumulates a ROWS x COLS 2-D histogram of (x_index, y_index) sample pairs over a programmable dwell of valid samples, then freezes the histogram for readout.
- Adds sample qualification, saturating counters, a sequenced clear, a dwell FSM, a registered random-access read port and status flags.
- Sits after the symbol quantiser; a host or control FSM reads the bins.

Parameters:
- IDX_W, 6, width of x_index and y_index.
- RANGE_X_MIN, 0, lowest accepted x (inclusive); accepted x is RANGE_X_MIN..RANGE_X_MIN+ROWS-1.
- RANGE_Y_MIN, 0, lowest accepted y (inclusive); accepted y is RANGE_Y_MIN..RANGE_Y_MIN+COLS-1.
- ROWS, 3, histogram rows, indexed by x.
- COLS, 3, histogram columns, indexed by y.
- CNT_W, 8, bin counter width.
- DWELL_W, 16, width of the dwell length and the sample counters.

Ports:
- clk, in, 1: clock, rising edge.
- rst, in, 1: synchronous, active-high reset.
- start, in, 1: pulse that begins a clear-then-accumulate run.
- dwell_len, in, DWELL_W: number of valid samples per run; captured on an accepted start.
- sample_valid, in, 1: x_index/y_index qualifier.
- x_index, in, IDX_W: sample row coordinate.
- y_index, in, IDX_W: sample column coordinate.
- rd_en, in, 1: read request.
- rd_row, in, $clog2(ROWS): read row.
- rd_col, in, $clog2(COLS): read column.
- rd_data, out, CNT_W: bin value, registered.
- rd_valid, out, 1: rd_data qualifier.
- busy, out, 1: high in CLEAR or ACCUM.
- done, out, 1: high in DONE.
- sat_flag, out, 1: sticky; any bin reached its maximum this run.
- hit_count, out, DWELL_W: in-range samples counted this run.

Behaviour:
- Reset (rst high at a clock edge):
  - All bins are set to 0.
  - State goes to IDLE.
  - rd_data, rd_valid, done, sat_flag and hit_count are set to 0.
  - Reset takes priority over every other input, including mid-CLEAR and mid-ACCUM.
- Bin mapping: bin(r,c) with r = x_index - RANGE_X_MIN and c = y_index - RANGE_Y_MIN.
- In-range test: x_index in [RANGE_X_MIN, RANGE_X_MIN+ROWS-1] and y_index in [RANGE_Y_MIN, RANGE_Y_MIN+COLS-1].
- FSM states: IDLE, CLEAR, ACCUM, DONE.
- IDLE or DONE, start=1:
  - Go to CLEAR.
  - Capture dwell_len; clear sat_flag and hit_count; reset the sample counter to 0.
- CLEAR:
  - Zeroes one bin per cycle, in linear order r*COLS+c from 0 to ROWS*COLS-1, taking exactly ROWS*COLS cycles.
  - Then go to ACCUM; if the captured dwell_len is 0, go directly to DONE.
  - Samples arriving during CLEAR are dropped.
- ACCUM:
  - Each cycle with sample_valid=1 increments the sample counter, whether or not the sample is in range.
  - If the sample is in range and the bin is below 2^CNT_W-1, the bin increments by 1 and hit_count increments by 1.
  - If the bin is already at 2^CNT_W-1, the bin holds, sat_flag goes to 1, and hit_count still increments.
  - When the sample counter reaches the captured dwell_len (the dwell_len-th valid sample is counted in that same cycle), go to DONE on the next edge.
- DONE: bins and flags are frozen; done=1 until the next start.
- start is ignored in CLEAR and ACCUM; no restart mid-run.
- Read port:
  - Available in every state.
  - rd_en at edge N gives rd_data and rd_valid at edge N+1 (1-cycle latency).
  - rd_valid is 0 in cycles with no read.
  - rd_row >= ROWS or rd_col >= COLS returns 0 with rd_valid=1.
  - A read of a bin that is being incremented in the same cycle returns the pre-increment value.
  - A read during CLEAR returns the bin's current stored value.
- Counter widths: bins wrap never; they saturate. hit_count never exceeds dwell_len, so it cannot overflow.
- Reset mid-run: the run is abandoned and all bins read 0 afterwards, with no CLEAR sweep needed.

Test Plan:
- Reset then read all 9 bins -> each rd_data=0, rd_valid=1 one cycle after each rd_en; done=0, busy=0.
- start with dwell_len=5; samples (0,0),(0,0),(2,1),(7,7),(1,2), all valid -> busy for 9 clear cycles plus 5 cycles; in DONE, bin(0,0)=2, bin(2,1)=1, bin(1,2)=1, all other bins 0, hit_count=4, done=1.
- CNT_W=4, dwell_len=20, all 20 samples at (1,1) -> bin(1,1)=15, sat_flag=1, hit_count=20.
- Second start after DONE with dwell_len=0 -> CLEAR sweep zeroes all bins, then DONE directly; bin(1,1)=0, sat_flag=0, hit_count=0.
- During ACCUM: sample_valid low for 3 cycles; start pulsed; rd_en on bin(0,0) concurrent with a (0,0) sample -> idle cycles are not counted, start is ignored, read returns the old value and the next read returns the old value +1.
- rst asserted mid-ACCUM -> next cycle state is IDLE, all outputs 0; reads of every bin return 0.
